booth_op_sequencer: RTL and testbench
=====================================

BOOTH_OP_SEQUENCER -- requirements
Module: booth_op_sequencer

Interface
REQ-001 SHALL have parameter ITER, default 4: number of Booth iterations the multiplier core needs after load.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: operand FIFO entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: an operand pair is offered.
REQ-006 SHALL have port in_ready, output, 1: FIFO can accept a pair.
REQ-007 SHALL have port in_mr, input, 4: signed multiplier operand.
REQ-008 SHALL have port in_md, input, 4: signed multiplicand operand.
REQ-009 SHALL have port mul_load, output, 1: load/hold strobe to the Booth core (drives its rst).
REQ-010 SHALL have port mul_mr, output, 4: multiplier operand to the core (drives its mr_in).
REQ-011 SHALL have port mul_md, output, 4: multiplicand operand to the core (drives its md).
REQ-012 SHALL have port mul_out, input, 8: product from the core.
REQ-013 SHALL have port res_valid, output, 1: captured product available.
REQ-014 SHALL have port res_ready, input, 1: consumer accepts the product.
REQ-015 SHALL have port res_prod, output, 8: signed product.
REQ-016 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-017 SHALL push {in_mr,in_md} into the FIFO on a rising edge with in_valid and in_ready both high; in_ready SHALL equal not-full and SHALL be registered-state based, with no combinational path from in_valid.
REQ-018 SHALL implement FSM states IDLE, LOAD, RUN, CAPT.
REQ-019 SHALL go IDLE->LOAD when the FIFO is non-empty and (res_valid is 0 or res_ready is 1); on that edge it pops the FIFO head into mul_mr/mul_md.
REQ-020 SHALL go LOAD->RUN after exactly one cycle.
REQ-021 SHALL stay in RUN for exactly ITER cycles, counted by an iteration counter cleared on entry, then go to CAPT.
REQ-022 SHALL, in CAPT, register mul_out into res_prod, set res_valid, and go to IDLE.
REQ-023 SHALL drive mul_load 1 in IDLE and LOAD, and 0 in RUN and CAPT; mul_mr/mul_md SHALL be stable from LOAD through CAPT.
REQ-024 SHALL clear res_valid on an edge with res_valid and res_ready both high, unless CAPT sets it on the same edge.
REQ-025 SHALL make res_valid rise ITER+3 edges after acceptance when idle and empty (7 edges at ITER=4); steady-state throughput with res_ready=1 SHALL be one result per ITER+3 cycles.
REQ-026 SHALL NOT alter the FIFO on a push while full, nor on a pop while empty; simultaneous push and pop with occupancy 1 SHALL leave occupancy at 1.
REQ-027 SHALL make FIFO pointers wrap modulo FIFO_DEPTH and preserve order.
REQ-028 SHALL hold res_prod and res_valid while res_ready is 0; no new LOAD SHALL start while res_valid is 1 and res_ready is 0.

Reset
REQ-029 SHALL, on rst, immediately set: state IDLE; FIFO empty; in_ready 1; mul_load 1; mul_mr 0; mul_md 0; res_valid 0; res_prod 0; busy 0; counter 0.
REQ-030 SHALL, on rst asserted mid-operation (any state), discard the in-flight job and all FIFO contents; no result SHALL be produced for them.

Configuration
REQ-031 SHALL, with macro BOOTH_SEQ_ACC_EN defined, add port acc_clr (input, 1; synchronous clear) and port acc_out (output, 12; signed running sum of sign-extended captured products, updated in CAPT, wrapping modulo 2^12, reset 0, acc_clr in the same cycle as CAPT yielding the new product only).
REQ-032 SHALL, without BOOTH_SEQ_ACC_EN, have neither port nor accumulator logic, with all other behaviour identical.

Verification
REQ-033 SHALL cover: reset, push (mr=7, md=5), res_ready=1 -> res_prod=8'h23, res_valid high 7 edges after accept, mul_load low exactly 5 cycles.
REQ-034 SHALL cover: push (-8,-8) then (-8,7) back-to-back -> 8'h40 then 8'hC8, in order, results 7 cycles apart.
REQ-035 SHALL cover: res_ready=0, push 4 pairs -> in_ready low after FIFO fills plus one in flight; res_valid held; release -> all results in order.
REQ-036 SHALL cover: rst asserted during RUN with 2 queued -> all outputs at reset values asynchronously; no stray result after release.
REQ-037 SHALL cover: with BOOTH_SEQ_ACC_EN, products 35, -56, 64 -> acc_out 35, -21, 43 (12'h02B); acc_clr then acc_out=0.
REQ-038 SHALL cover: push while full and pop with FIFO empty -> occupancy and order unchanged.

Source files
------------

// File: rtl/booth_op_sequencer.sv
// Feeds operand pairs from a small FIFO into an iterative Booth multiplier core and captures its product.
// Optional running accumulator of captured products: define BOOTH_SEQ_ACC_EN.
module booth_op_sequencer #(
    parameter int ITER       = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_mr,
    input  logic [3:0]  in_md,
    output logic        mul_load,
    output logic [3:0]  mul_mr,
    output logic [3:0]  mul_md,
    input  logic [7:0]  mul_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_prod,
`ifdef BOOTH_SEQ_ACC_EN
    input  logic        acc_clr,
    output logic [11:0] acc_out,
`endif
    output logic        busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ITW   = $clog2(ITER + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] CAPT = 2'd3;

    logic [1:0]       state;
    logic [ITW-1:0]   iter_cnt;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             push;
    logic             pop;

    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign fifo_head  = fifo_mem[rd_ptr];

    // in_ready depends only on registered occupancy, never on in_valid.
    assign in_ready = ~fifo_full;
    assign push     = in_valid & ~fifo_full;
    assign pop      = (state == IDLE) & ~fifo_empty & (~res_valid | res_ready);

    assign mul_load = (state == IDLE) | (state == LOAD);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {in_mr, in_md};
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            iter_cnt <= '0;
            mul_mr   <= '0;
            mul_md   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state            <= LOAD;
                        {mul_mr, mul_md} <= fifo_head;
                    end
                end
                LOAD: begin
                    state    <= RUN;
                    iter_cnt <= '0;
                end
                RUN: begin
                    if (iter_cnt == ITW'(ITER - 1)) begin
                        state <= CAPT;
                    end else begin
                        iter_cnt <= iter_cnt + ITW'(1);
                    end
                end
                CAPT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A capture always wins over a same-cycle consumer handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_prod  <= '0;
        end else if (state == CAPT) begin
            res_valid <= 1'b1;
            res_prod  <= mul_out;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef BOOTH_SEQ_ACC_EN
    logic [11:0] prod_ext;

    assign prod_ext = {{4{mul_out[7]}}, mul_out};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out <= '0;
        end else if (state == CAPT) begin
            acc_out <= acc_clr ? prod_ext : (acc_out + prod_ext);
        end else if (acc_clr) begin
            acc_out <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Self-checking bench for booth_op_sequencer: directed vector table, corner sequences and randomized traffic.
// Exercises the accumulator too when BOOTH_SEQ_ACC_EN is defined.
module tb_booth_op_sequencer;

    localparam int ITER  = 4;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_mr;
    logic [3:0] in_md;
    logic       mul_load;
    logic [3:0] mul_mr;
    logic [3:0] mul_md;
    logic [7:0] mul_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_prod;
    logic       busy;
`ifdef BOOTH_SEQ_ACC_EN
    logic        acc_clr;
    logic [11:0] acc_out;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0] mr;
        logic [3:0] md;
        logic [7:0] prod;
    } vec_t;

    vec_t vecs [8];

    booth_op_sequencer #(.ITER(ITER), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mr     (in_mr),
        .in_md     (in_md),
        .mul_load  (mul_load),
        .mul_mr    (mul_mr),
        .mul_md    (mul_md),
        .mul_out   (mul_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_prod  (res_prod),
`ifdef BOOTH_SEQ_ACC_EN
        .acc_clr   (acc_clr),
        .acc_out   (acc_out),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] prod8(input logic [3:0] a, input logic [3:0] b);
        int x;
        x = $signed(a) * $signed(b);
        return x[7:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Core stand-in: product appears only after ITER clocks with the load strobe low.
    int core_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) core_cnt <= 0;
        else if (mul_load) core_cnt <= 0;
        else if (core_cnt < ITER) core_cnt <= core_cnt + 1;
    end
    assign mul_out = (core_cnt >= ITER) ? prod8(mul_mr, mul_md) : 8'h00;

    // Reference: a queue of pending pairs, one job at a time lasting ITER+2 cycles after its pop.
    logic [7:0] m_q [$];
    logic [7:0] exp_q [$];
    int         m_job_left;
    logic       m_valid;
    logic [7:0] m_prod;
    logic [3:0] m_mr;
    logic [3:0] m_md;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_job_left = 0;
            m_valid    = 1'b0;
            m_prod     = 8'h00;
            m_mr       = 4'h0;
            m_md       = 4'h0;
        end else begin
            bit do_pop;
            bit do_push;
            bit do_capt;
            do_capt = (m_job_left == 1);
            do_pop  = (m_job_left == 0) && (m_q.size() > 0) && (!m_valid || res_ready);
            do_push = in_valid && (m_q.size() < DEPTH);
            if (do_capt) begin
                m_valid = 1'b1;
                m_prod  = prod8(m_mr, m_md);
            end else if (m_valid && res_ready) begin
                m_valid = 1'b0;
            end
            if (do_pop) begin
                {m_mr, m_md} = m_q.pop_front();
                m_job_left   = ITER + 2;
            end else if (m_job_left > 0) begin
                m_job_left--;
            end
            if (do_push) begin
                m_q.push_back({in_mr, in_md});
                exp_q.push_back(prod8(in_mr, in_md));
            end
        end
    end

    logic [7:0] got_prod [$];
    int         got_cyc [$];

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("in_ready",  in_ready,  (m_q.size() < DEPTH));
            checkOutput("busy",      busy,      (m_job_left != 0));
            checkOutput("mul_load",  mul_load,  (m_job_left == 0) || (m_job_left == ITER + 2));
            checkOutput("res_valid", res_valid, m_valid);
            checkOutput("res_prod",  res_prod,  m_prod);
            checkOutput("mul_mr",    mul_mr,    m_mr);
            checkOutput("mul_md",    mul_md,    m_md);
            if (res_valid && res_ready) begin
                got_prod.push_back(res_prod);
                got_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_extra: got result 0x%0h, expected none", res_prod);
                end else begin
                    checkOutput("sb_order", res_prod, exp_q.pop_front());
                end
            end
        end
    end

    task automatic checkReset(input string tag);
        checkOutput({tag, "_in_ready"},  in_ready,  1);
        checkOutput({tag, "_mul_load"},  mul_load,  1);
        checkOutput({tag, "_mul_mr"},    mul_mr,    0);
        checkOutput({tag, "_mul_md"},    mul_md,    0);
        checkOutput({tag, "_res_valid"}, res_valid, 0);
        checkOutput({tag, "_res_prod"},  res_prod,  0);
        checkOutput({tag, "_busy"},      busy,      0);
`ifdef BOOTH_SEQ_ACC_EN
        checkOutput({tag, "_acc_out"},   acc_out,   0);
`endif
    endtask

    // Called at a negedge; returns at a negedge with in_valid low.
    task automatic pushPair(input logic [3:0] mr, input logic [3:0] md, input int limit);
        int k = 0;
        in_mr    = mr;
        in_md    = md;
        in_valid = 1'b1;
        while (!in_ready && k < limit) begin
            @(negedge clk);
            k++;
        end
        checkOutput("push_ready", in_ready, 1);
        if (in_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic waitResults(input int target, input int limit);
        int k = 0;
        while (got_prod.size() < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        checkOutput("wait_results", (got_prod.size() >= target), 1);
    endtask

    // Single job from idle: measures latency, load-low span and the product.
    task automatic applyStimulus(input vec_t v);
        int n = 0;
        int low = 0;
        bit seen = 0;
        @(negedge clk);
        res_ready = 1'b1;
        in_mr     = v.mr;
        in_md     = v.md;
        in_valid  = 1'b1;
        checkOutput("vec_in_ready", in_ready, 1);
        @(posedge clk);
        while (n < 30 && !seen) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (res_valid) begin
                seen = 1;
            end else begin
                if (!mul_load) low++;
                @(posedge clk);
                n++;
            end
        end
        checkOutput("vec_seen", seen, 1);
        checkOutput("vec_latency", n, ITER + 3);
        checkOutput("vec_load_low", low, ITER + 1);
        checkOutput("vec_prod", res_prod, v.prod);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gsz;
        vecs[0] = '{4'd7, 4'd5, 8'h23};
        vecs[1] = '{4'h8, 4'h8, 8'h40};
        vecs[2] = '{4'h8, 4'd7, 8'hC8};
        vecs[3] = '{4'hF, 4'hF, 8'h01};
        vecs[4] = '{4'd7, 4'h8, 8'hC8};
        vecs[5] = '{4'd0, 4'd5, 8'h00};
        vecs[6] = '{4'h8, 4'd1, 8'hF8};
        vecs[7] = '{4'd3, 4'hD, 8'hF7};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mr     = 4'h0;
        in_md     = 4'h0;
        res_ready = 1'b1;
`ifdef BOOTH_SEQ_ACC_EN
        acc_clr   = 1'b0;
`endif
        #12;
        checkReset("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
        end

        // Back-to-back pushes: results in order, ITER+3 cycles apart.
        @(negedge clk);
        res_ready = 1'b1;
        gsz = got_prod.size();
        pushPair(4'h8, 4'h8, 20);
        pushPair(4'h8, 4'd7, 20);
        waitResults(gsz + 2, 60);
        if (got_prod.size() >= gsz + 2) begin
            checkOutput("b2b_first",  got_prod[gsz],     8'h40);
            checkOutput("b2b_second", got_prod[gsz + 1], 8'hC8);
            checkOutput("b2b_spacing", got_cyc[gsz + 1] - got_cyc[gsz], ITER + 3);
        end

        // Back-pressure: FIFO fills behind one in-flight job, result is held.
        @(negedge clk);
        res_ready = 1'b0;
        gsz = got_prod.size();
        pushPair(4'd3, 4'd4, 20);
        pushPair(4'hE, 4'd5, 20);
        pushPair(4'h9, 4'hD, 20);
        checkOutput("fill_in_ready", in_ready, 0);
        fork
            pushPair(4'd6, 4'hF, 80);
            begin
                int k = 0;
                while (!res_valid && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                for (int h = 0; h < 4; h++) begin
                    @(negedge clk);
                    checkOutput("hold_valid", res_valid, 1);
                    checkOutput("hold_prod",  res_prod,  8'h0C);
                    checkOutput("hold_busy",  busy,      0);
                    checkOutput("hold_ready", in_ready,  0);
                end
                res_ready = 1'b1;
            end
        join
        waitResults(gsz + 4, 100);
        if (got_prod.size() >= gsz + 4) begin
            checkOutput("bp_r0", got_prod[gsz],     8'h0C);
            checkOutput("bp_r1", got_prod[gsz + 1], 8'hF6);
            checkOutput("bp_r2", got_prod[gsz + 2], 8'h15);
            checkOutput("bp_r3", got_prod[gsz + 3], 8'hFA);
        end

        // Push while full is dropped; idle with empty FIFO produces nothing.
        @(negedge clk);
        res_ready = 1'b0;
        gsz = got_prod.size();
        pushPair(4'd1, 4'd1, 20);
        pushPair(4'hF, 4'd7, 20);
        pushPair(4'd5, 4'd5, 20);
        in_mr    = 4'd2;
        in_md    = 4'd2;
        in_valid = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            checkOutput("full_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        waitResults(gsz + 3, 100);
        repeat (20) @(negedge clk);
        checkOutput("full_count", got_prod.size(), gsz + 3);
        checkOutput("full_idle",  busy, 0);
        if (got_prod.size() >= gsz + 3) begin
            checkOutput("full_r0", got_prod[gsz],     8'h01);
            checkOutput("full_r1", got_prod[gsz + 1], 8'hF9);
            checkOutput("full_r2", got_prod[gsz + 2], 8'h19);
        end

        // Reset in RUN with two pairs queued.
        @(negedge clk);
        res_ready = 1'b1;
        pushPair(4'd2, 4'd3, 20);
        pushPair(4'd4, 4'd4, 20);
        pushPair(4'd5, 4'hE, 20);
        checkOutput("pre_rst_run", (busy && !mul_load), 1);
        gsz = got_prod.size();
        #2 rst = 1'b1;
        #1 checkReset("async_rst");
        @(negedge clk);
        checkReset("held_rst");
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("no_stray", got_prod.size(), gsz);
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_ready", in_ready, 1);

`ifdef BOOTH_SEQ_ACC_EN
        // Accumulator: 35, -56, 64 then clear.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        gsz = got_prod.size();
        pushPair(4'd7, 4'd5, 20);
        waitResults(gsz + 1, 40);
        checkOutput("acc_1", acc_out, 12'd35);
        pushPair(4'h8, 4'd7, 20);
        waitResults(gsz + 2, 40);
        checkOutput("acc_2", acc_out, 12'hFEB);
        pushPair(4'h8, 4'h8, 20);
        waitResults(gsz + 3, 40);
        checkOutput("acc_3", acc_out, 12'h02B);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        checkOutput("acc_clr", acc_out, 12'h000);
`endif

        // Randomized traffic checked cycle by cycle against the reference.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) == 1);
            in_mr     = 4'($urandom);
            in_md     = 4'($urandom);
            res_ready = ($urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        begin
            int k = 0;
            while ((exp_q.size() != 0 || busy || res_valid) && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        checkOutput("drain_empty", exp_q.size(), 0);
        checkOutput("drain_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
